// File: rtl/latency_meter_pkg.sv
// Shared definitions for the latency meter: channel state encoding and default parameters.
package latency_meter_pkg;

    localparam int unsigned DEF_N_CH    = 2;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_TIMEOUT = 1000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ARMED = ST_ARMED,
        DONE  = ST_DONE
    } ch_state_t;

endpackage

// File: rtl/latency_meter_ch.sv
// One measurement channel: counts cycles from a kick to the next rising edge of sig, or gives up at TIMEOUT.
module latency_meter_ch
    import latency_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kick,
    input  logic             sig,
    output logic [CNT_W-1:0] meas,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    if (TIMEOUT == 0 || 64'(TIMEOUT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_timeout
        $error("latency_meter_ch: TIMEOUT must be in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    ch_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sig_q;
    logic             rise;

    assign cnt_next = cnt + 1'b1;
    assign rise     = sig & ~sig_q;
    assign busy     = (state == ARMED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            meas    <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            sig_q   <= 1'b0;
        end else begin
            sig_q <= sig;
            // kick takes priority over any rise or timeout seen on the same edge
            if (kick) begin
                state   <= ARMED;
                cnt     <= '0;
                valid   <= 1'b0;
                timeout <= 1'b0;
            end else if (state == ARMED) begin
                if (rise) begin
                    meas  <= cnt_next;
                    valid <= 1'b1;
                    state <= DONE;
                end else if (cnt_next == TMO) begin
                    meas    <= TMO;
                    timeout <= 1'b1;
                    state   <= IDLE;
                end else begin
                    cnt <= cnt_next;
                end
            end
        end
    end

endmodule

// File: rtl/latency_meter.sv
// Multi-channel kick-to-rise latency meter; N_CH independent channels with packed outputs.
module latency_meter
    import latency_meter_pkg::*;
#(
    parameter int unsigned N_CH    = DEF_N_CH,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_CH-1:0]       kick_i,
    input  logic [N_CH-1:0]       sig_i,
    output logic [N_CH*CNT_W-1:0] meas_o,
    output logic [N_CH-1:0]       valid_o,
    output logic [N_CH-1:0]       timeout_o,
    output logic [N_CH-1:0]       busy_o
);

    if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
        $error("latency_meter: N_CH must be in 1..32");
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        latency_meter_ch #(
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk     (clk_i),
            .rst     (rst_i),
            .kick    (kick_i[g]),
            .sig     (sig_i[g]),
            .meas    (meas_o[g*CNT_W +: CNT_W]),
            .valid   (valid_o[g]),
            .timeout (timeout_o[g]),
            .busy    (busy_o[g])
        );
    end

endmodule

// File: tb/tb_latency_meter.sv
// Self-checking bench for latency_meter: directed boundary scenarios plus randomized multi-channel traffic.
module tb_latency_meter;

    localparam int unsigned CW    = 16;
    localparam int unsigned TMO_B = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [1:0]      ka = '0, sa = '0;
    logic [2*CW-1:0] meas_a;
    logic [1:0]      valid_a, tmo_a, busy_a;

    logic [3:0]      kb = '0, sb = '0;
    logic [4*CW-1:0] meas_b;
    logic [3:0]      valid_b, tmo_b, busy_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    latency_meter #(.N_CH(2), .CNT_W(CW), .TIMEOUT(1000)) dut_a (
        .clk_i(clk), .rst_i(rst), .kick_i(ka), .sig_i(sa),
        .meas_o(meas_a), .valid_o(valid_a), .timeout_o(tmo_a), .busy_o(busy_a)
    );

    latency_meter #(.N_CH(4), .CNT_W(CW), .TIMEOUT(TMO_B)) dut_b (
        .clk_i(clk), .rst_i(rst), .kick_i(kb), .sig_i(sb),
        .meas_o(meas_b), .valid_o(valid_b), .timeout_o(tmo_b), .busy_o(busy_b)
    );

    // Reference model for dut_b: latency expressed as edge-number difference e - k.
    int unsigned e_cnt;
    int unsigned k_edge [4];
    int unsigned m_meas [4];
    bit          m_armed[4], m_valid[4], m_tmo[4], m_prev[4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_cnt = 0;
            for (int ch = 0; ch < 4; ch++) begin
                k_edge[ch] = 0; m_meas[ch] = 0; m_armed[ch] = 0;
                m_valid[ch] = 0; m_tmo[ch] = 0; m_prev[ch] = 0;
            end
        end else begin
            e_cnt++;
            for (int ch = 0; ch < 4; ch++) begin
                if (kb[ch]) begin
                    m_armed[ch] = 1; k_edge[ch] = e_cnt; m_valid[ch] = 0; m_tmo[ch] = 0;
                end else if (m_armed[ch] && sb[ch] && !m_prev[ch]) begin
                    m_meas[ch] = e_cnt - k_edge[ch]; m_valid[ch] = 1; m_armed[ch] = 0;
                end else if (m_armed[ch] && (e_cnt - k_edge[ch]) == TMO_B) begin
                    m_meas[ch] = TMO_B; m_tmo[ch] = 1; m_armed[ch] = 0;
                end
                m_prev[ch] = sb[ch];
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks++;
        if (meas_a !== '0 || valid_a !== 2'b00 || tmo_a !== 2'b00 || busy_a !== 2'b00) begin
            failures++;
            $display("FAIL reset_a meas=%h valid=%b tmo=%b busy=%b required all zero", meas_a, valid_a, tmo_a, busy_a);
        end
        checks++;
        if (meas_b !== '0 || valid_b !== 4'b0 || tmo_b !== 4'b0 || busy_b !== 4'b0) begin
            failures++;
            $display("FAIL reset_b meas=%h valid=%b tmo=%b busy=%b required all zero", meas_b, valid_b, tmo_b, busy_b);
        end
        step(2);
        #3 rst = 1'b0;
        step(2);
    endtask

    task automatic test_basic;
        ka = 2'b11;
        step(1);
        ka = 2'b00;
        checks++;
        if (busy_a !== 2'b11) begin failures++; $display("FAIL basic_busy_armed got=%b exp=11", busy_a); end
        step(9);
        checks++;
        if (valid_a !== 2'b00 || busy_a !== 2'b11) begin
            failures++; $display("FAIL basic_pre valid=%b busy=%b exp valid=00 busy=11", valid_a, busy_a);
        end
        sa = 2'b01;
        step(1);
        checks++;
        if (meas_a[0 +: CW] !== 16'd10) begin failures++; $display("FAIL basic_meas0 got=%0d exp=10", meas_a[0 +: CW]); end
        checks++;
        if (valid_a !== 2'b01 || busy_a !== 2'b10) begin
            failures++; $display("FAIL basic_edge20 valid=%b busy=%b exp valid=01 busy=10", valid_a, busy_a);
        end
        step(9);
        sa = 2'b11;
        step(1);
        checks++;
        if (meas_a[CW +: CW] !== 16'd20) begin failures++; $display("FAIL basic_meas1 got=%0d exp=20", meas_a[CW +: CW]); end
        checks++;
        if (meas_a[0 +: CW] !== 16'd10) begin failures++; $display("FAIL basic_meas0_hold got=%0d exp=10", meas_a[0 +: CW]); end
        checks++;
        if (valid_a !== 2'b11 || busy_a !== 2'b00 || tmo_a !== 2'b00) begin
            failures++; $display("FAIL basic_edge30 valid=%b busy=%b tmo=%b exp 11/00/00", valid_a, busy_a, tmo_a);
        end
        sa = 2'b00;
        step(1);
    endtask

    task automatic test_timeout;
        kb[0] = 1'b1;
        step(1);
        kb[0] = 1'b0;
        step(7);
        checks++;
        if (busy_b[0] !== 1'b1 || tmo_b[0] !== 1'b0) begin
            failures++; $display("FAIL timeout_pre busy=%b tmo=%b exp 1/0", busy_b[0], tmo_b[0]);
        end
        step(1);
        checks++;
        if (tmo_b[0] !== 1'b1 || valid_b[0] !== 1'b0 || busy_b[0] !== 1'b0 || meas_b[0 +: CW] !== 16'd8) begin
            failures++;
            $display("FAIL timeout_hit tmo=%b valid=%b busy=%b meas=%0d exp 1/0/0/8", tmo_b[0], valid_b[0], busy_b[0], meas_b[0 +: CW]);
        end
        step(3);
        checks++;
        if (tmo_b[0] !== 1'b1 || meas_b[0 +: CW] !== 16'd8) begin
            failures++; $display("FAIL timeout_sticky tmo=%b meas=%0d exp 1/8", tmo_b[0], meas_b[0 +: CW]);
        end
    endtask

    task automatic test_kick_rise_same;
        kb[1] = 1'b1; sb[1] = 1'b1;
        step(1);
        kb[1] = 1'b0; sb[1] = 1'b0;
        checks++;
        if (valid_b[1] !== 1'b0 || busy_b[1] !== 1'b1) begin
            failures++; $display("FAIL kick_wins valid=%b busy=%b exp 0/1", valid_b[1], busy_b[1]);
        end
        step(2);
        sb[1] = 1'b1;
        step(1);
        checks++;
        if (valid_b[1] !== 1'b1 || meas_b[CW +: CW] !== 16'd3) begin
            failures++; $display("FAIL kick_then_k3 valid=%b meas=%0d exp 1/3", valid_b[1], meas_b[CW +: CW]);
        end
        sb[1] = 1'b0;
        step(1);
    endtask

    task automatic test_min_latency;
        kb[2] = 1'b1;
        step(1);
        kb[2] = 1'b0; sb[2] = 1'b1;
        step(1);
        checks++;
        if (valid_b[2] !== 1'b1 || meas_b[2*CW +: CW] !== 16'd1 || busy_b[2] !== 1'b0) begin
            failures++;
            $display("FAIL min_latency valid=%b meas=%0d busy=%b exp 1/1/0", valid_b[2], meas_b[2*CW +: CW], busy_b[2]);
        end
        sb[2] = 1'b0;
        step(1);
    endtask

    task automatic test_rise_at_timeout;
        kb[3] = 1'b1;
        step(1);
        kb[3] = 1'b0;
        step(7);
        sb[3] = 1'b1;
        step(1);
        checks++;
        if (valid_b[3] !== 1'b1 || tmo_b[3] !== 1'b0 || meas_b[3*CW +: CW] !== 16'd8) begin
            failures++;
            $display("FAIL rise_at_timeout valid=%b tmo=%b meas=%0d exp 1/0/8", valid_b[3], tmo_b[3], meas_b[3*CW +: CW]);
        end
        sb[3] = 1'b0;
        step(1);
    endtask

    task automatic test_restart;
        kb[0] = 1'b1;
        step(1);
        kb[0] = 1'b0;
        checks++;
        if (tmo_b[0] !== 1'b0 || busy_b[0] !== 1'b1) begin
            failures++; $display("FAIL restart_clear tmo=%b busy=%b exp 0/1", tmo_b[0], busy_b[0]);
        end
        step(4);
        kb[0] = 1'b1;
        step(1);
        kb[0] = 1'b0;
        step(2);
        sb[0] = 1'b1;
        step(1);
        checks++;
        if (valid_b[0] !== 1'b1 || meas_b[0 +: CW] !== 16'd3) begin
            failures++; $display("FAIL restart_meas valid=%b meas=%0d exp 1/3", valid_b[0], meas_b[0 +: CW]);
        end
        // sig stays high across the next kick: no result until it falls and rises again
        kb[0] = 1'b1;
        step(1);
        kb[0] = 1'b0;
        step(4);
        checks++;
        if (valid_b[0] !== 1'b0 || busy_b[0] !== 1'b1) begin
            failures++; $display("FAIL restart_high_sig valid=%b busy=%b exp 0/1", valid_b[0], busy_b[0]);
        end
        sb[0] = 1'b0;
        step(1);
        sb[0] = 1'b1;
        step(1);
        checks++;
        if (valid_b[0] !== 1'b1 || meas_b[0 +: CW] !== 16'd6) begin
            failures++; $display("FAIL restart_rerise valid=%b meas=%0d exp 1/6", valid_b[0], meas_b[0 +: CW]);
        end
        sb[0] = 1'b0;
        step(1);
    endtask

    task automatic test_async_reset;
        kb = 4'b0011; ka = 2'b01;
        step(1);
        kb = '0; ka = '0;
        step(1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (meas_a !== '0 || valid_a !== 2'b00 || tmo_a !== 2'b00 || busy_a !== 2'b00) begin
            failures++; $display("FAIL async_reset_a meas=%h valid=%b tmo=%b busy=%b exp zero", meas_a, valid_a, tmo_a, busy_a);
        end
        checks++;
        if (meas_b !== '0 || valid_b !== 4'b0 || tmo_b !== 4'b0 || busy_b !== 4'b0) begin
            failures++; $display("FAIL async_reset_b meas=%h valid=%b tmo=%b busy=%b exp zero", meas_b, valid_b, tmo_b, busy_b);
        end
        #2 rst = 1'b0;
        step(1);
        sb = 4'b0011; sa = 2'b01;
        step(1);
        checks++;
        if (valid_b !== 4'b0 || busy_b !== 4'b0 || valid_a !== 2'b00 || meas_b !== '0) begin
            failures++; $display("FAIL post_reset_rise valid_b=%b busy_b=%b valid_a=%b exp zero", valid_b, busy_b, valid_a);
        end
        sb = '0; sa = '0;
        step(1);
    endtask

    task automatic test_random_channels;
        for (int c = 0; c < 600; c++) begin
            for (int ch = 0; ch < 4; ch++) begin
                kb[ch] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0) sb[ch] = ~sb[ch];
            end
            step(1);
            for (int ch = 0; ch < 4; ch++) begin
                checks++;
                if (meas_b[ch*CW +: CW] !== CW'(m_meas[ch]) || valid_b[ch] !== m_valid[ch] ||
                    tmo_b[ch] !== m_tmo[ch] || busy_b[ch] !== m_armed[ch]) begin
                    failures++;
                    $display("FAIL random cyc%0d ch%0d got meas=%0d v=%b t=%b b=%b exp meas=%0d v=%b t=%b b=%b",
                             c, ch, meas_b[ch*CW +: CW], valid_b[ch], tmo_b[ch], busy_b[ch],
                             m_meas[ch], m_valid[ch], m_tmo[ch], m_armed[ch]);
                end
            end
        end
        kb = '0; sb = '0;
        step(2);
    endtask

    initial begin
        #1;
        test_reset;
        test_basic;
        test_timeout;
        test_kick_rise_same;
        test_min_latency;
        test_rise_at_timeout;
        test_restart;
        test_async_reset;
        test_random_channels;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/latency_meter.md
LATENCY_METER -- requirements
Module: latency_meter

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent measurement channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 16: width of each measurement result in clock cycles.
REQ-003 SHALL have parameter TIMEOUT, default 1000: cycle count at which an armed channel gives up; legal range 1..2**CNT_W-1.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port kick_i, input, N_CH: per-channel arm strobe, sampled on clk_i.
REQ-007 SHALL have port sig_i, input, N_CH: per-channel monitored signal, already synchronous to clk_i.
REQ-008 SHALL have port meas_o, output, N_CH*CNT_W: per-channel result, channel i at bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port valid_o, output, N_CH: per-channel result-valid flag, sticky.
REQ-010 SHALL have port timeout_o, output, N_CH: per-channel timeout flag, sticky.
REQ-011 SHALL have port busy_o, output, N_CH: per-channel armed indicator.

Function
REQ-012 Each channel SHALL run an independent FSM with states IDLE, ARMED and DONE; channels SHALL share only clk_i and rst_i.
REQ-013 A rising edge on sig_i[i] SHALL be detected at clock edge e when sig_i[i] is 1 at e and its registered copy from e-1 is 0; the registered copy SHALL update every cycle in every state.
REQ-014 kick_i[i]=1 at edge k SHALL take the channel to ARMED, clear cnt to 0, and clear valid_o[i] and timeout_o[i]. This applies from any state, including ARMED, where it restarts the measurement.
REQ-015 A rise detected at the same edge as kick_i[i] SHALL be ignored: kick wins.
REQ-016 In ARMED with no kick, each edge SHALL increment cnt by 1.
REQ-017 In ARMED, a rise at edge e SHALL load meas_o[i] with e-k (cnt+1), set valid_o[i] and go to DONE.
- Minimum result is 1: a rise at edge k+1.
REQ-018 In ARMED with no rise, when cnt+1 equals TIMEOUT at edge e, the channel SHALL load meas_o[i]=TIMEOUT, set timeout_o[i], leave valid_o[i] at 0 and go to IDLE.
REQ-019 If a rise and cnt+1==TIMEOUT occur at the same edge, the rise SHALL win: valid result equal to TIMEOUT, timeout_o stays 0.
REQ-020 busy_o[i] SHALL be 1 exactly while the channel is in ARMED.
REQ-021 In IDLE and DONE, rises SHALL be ignored, and meas_o, valid_o and timeout_o SHALL hold.
REQ-022 cnt SHALL be CNT_W bits and SHALL never wrap, because TIMEOUT bounds it.
REQ-023 Output latency SHALL be one clock: flags and meas_o change at the edge where the event is sampled, with no combinational input-to-output paths.

Reset
REQ-024 When rst_i is asserted, every channel SHALL be forced immediately to IDLE, with cnt=0, meas_o=0, valid_o=0, timeout_o=0, busy_o=0 and the registered sig copy=0.
REQ-025 Assertion of rst_i mid-measurement SHALL abort it with no result; after deassertion a new kick is required.
REQ-026 Reset deassertion SHALL be synchronised by the integrator, not by this block.

Structure
REQ-027 Package latency_meter_pkg SHALL hold the channel state enum (IDLE, ARMED, DONE) and the default parameter constants.
REQ-028 The per-channel logic SHALL be sub-module latency_meter_ch, with parameters CNT_W and TIMEOUT.
- latency_meter SHALL instantiate N_CH copies of it with a generate loop and pack the outputs.
REQ-029 Elaboration SHALL fail when TIMEOUT is 0 or TIMEOUT > 2**CNT_W-1.

Verification
REQ-030 Basic, N_CH=2: kick both at cycle 10; rise on ch0 at cycle 20 and on ch1 at cycle 30 -> meas ch0=10, ch1=20; valid_o=2'b11; busy_o drops at cycles 20 and 30.
REQ-031 Timeout, TIMEOUT=8: kick ch0 with no rise -> at cycle k+8, timeout_o[0]=1, meas=8, valid_o[0]=0, busy_o[0]=0.
REQ-032 Boundaries, tested separately:
- Rise at the kick edge is ignored; the next rise at k+3 gives meas=3.
- Rise at k+1 gives meas=1.
- Rise coinciding with the TIMEOUT edge gives a valid result of 8.
REQ-033 Restart: kick at 10, re-kick at 15, rise at 18 -> meas=3; a rise already high before the kick gives no result until it falls and rises again.
REQ-034 Reset: assert rst_i asynchronously between clock edges while ARMED -> all outputs are 0 immediately; a rise after release gives no result.
REQ-035 Channel independence, N_CH=4: random kicks and rises per channel -> each meas_o matches a scoreboard of e-k per channel.
